bus_master: RTL and testbench
=============================

// Module: bus_master
// PURPOSE
//  Initiator-side engine for the shared 2-master/2-slave arbitrated bus. Connects to one master
//  port (Mx_*) of the bus block. Accepts single or burst read/write commands from local logic,
//  requests the bus, waits for grant, issues one beat per granted cycle, then returns read data
//  and a completion pulse.
// PARAMETERS
//  ADDR_W  8   bus address width
//  DATA_W  32  bus data width
//  LEN_W   4   burst length field width; beats = cmd_len+1, so 1..16 beats
//  RD_LAT  1   cycles from beat issue (address on bus while granted) to valid M_din, 1..4
// PORTS
//  clk        in   1       clock, rising edge
//  reset_n    in   1       asynchronous active-low reset
//  cmd_valid  in   1       command offered
//  cmd_ready  out  1       command accepted when cmd_valid&cmd_ready
//  cmd_wr     in   1       1=write burst, 0=read burst
//  cmd_addr   in   ADDR_W  start address
//  cmd_len    in   LEN_W   beats minus one
//  wr_data    in   DATA_W  write data for current beat
//  wr_pop     out  1       wr_data consumed this cycle; source advances to the next word
//  rsp_valid  out  1       read data valid, one pulse per read beat
//  rsp_data   out  DATA_W  read data
//  done       out  1       one-cycle pulse when the command fully completes
//  M_req      out  1       bus request to arbiter
//  M_grant    in   1       grant from arbiter
//  M_wr       out  1       bus write strobe
//  M_address  out  ADDR_W  bus address
//  M_dout     out  DATA_W  bus write data
//  M_din      in   DATA_W  bus read data
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, read pipe flushed. Reset asserted mid-burst drops M_req
//   asynchronously; the command is abandoned; no done.
//  States: IDLE -> REQ -> XFER -> DRAIN -> IDLE.
//   IDLE: cmd_ready=1. On handshake, latch wr/addr/len and set M_req=1 -> REQ.
//   REQ: hold M_req; on M_grant=1 -> XFER. Waits indefinitely; no timeout.
//   XFER: a beat issues in each cycle with M_grant=1. It drives M_address=cur_addr and
//    M_wr=cmd_wr. For writes it also drives M_dout=wr_data and asserts wr_pop.
//    On issue: cur_addr+1 mod 2^ADDR_W (0xFF wraps to 0x00); beats remaining -1.
//    If M_grant falls mid-burst: no beat issues, M_wr=0, M_req stays 1, address holds,
//     and the burst resumes when grant returns.
//    After the last beat: M_req=0 next cycle. Write -> IDLE with done=1 in that cycle.
//     Read -> DRAIN.
//   DRAIN: wait until the last read beat's data is returned, then done=1 -> IDLE.
//  Read return: each beat issued at cycle t gives rsp_valid=1, rsp_data=M_din at cycle t+RD_LAT.
//   Tracked by an RD_LAT-deep valid shift register. No backpressure on rsp.
//  M_wr and M_dout are 0 whenever no write beat is issuing; M_address holds its last value.
//  cmd_ready=0 outside IDLE; a new command is accepted at the earliest the cycle after done.
//  Minimum single-beat latency: handshake -> req +1 -> grant seen (arbiter-dependent) ->
//   beat -> done +1 (write) or +RD_LAT+1 (read).
// STRUCTURE
//  Shared package bus_pkg: ADDR_W/DATA_W defaults, state encoding localparams
//   (ST_IDLE, ST_REQ, ST_XFER, ST_DRAIN), max RD_LAT constant.
//  One sub-module bus_master_rdpipe: RD_LAT valid shift register plus outstanding-beat counter.
//   Inputs issue/M_din; outputs rsp_valid/rsp_data/empty.
// TESTING
//  1 Single write addr 0x0A, data 0x0000_0004, immediate grant -> one cycle with M_wr=1,
//    M_address=0x0A, M_dout=0x0000_0004, wr_pop=1; done one cycle later.
//  2 Read burst addr 0x1E, len 3, M_din=addr+0x100 -> M_address 1E,1F,20,21.
//    rsp_data 0x11E..0x121 each RD_LAT after issue; done after the 4th rsp.
//  3 Wrap: read addr 0xFE, len 3 -> addresses FE,FF,00,01.
//  4 Contention: grant withheld 5 cycles after req -> M_req held, no beats, cmd_ready=0;
//    then the burst completes normally.
//  5 Grant drops for 2 cycles after beat 2 of an 8-beat write -> M_wr=0 and wr_pop=0 in the gap.
//    Beat 3 resumes at the next address; total 8 wr_pops.
//  6 reset_n low mid-burst -> M_req/M_wr/rsp_valid/done go 0 immediately.
//    After release: IDLE, cmd_ready=1, a new single read completes.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared defaults and state encoding for the arbitrated-bus initiator engine.
package bus_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int DATA_W_DEFAULT = 32;
  localparam int LEN_W_DEFAULT  = 4;
  localparam int MAX_RD_LAT     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_XFER  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/bus_master_rdpipe.sv
// Read-return tracker: flags the cycle each issued read beat's data appears on M_din
// and counts beats still in flight.
module bus_master_rdpipe
  import bus_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue,
  input  logic [DATA_W-1:0] M_din,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              empty
);

  localparam int CNT_W = $clog2(MAX_RD_LAT + 1);

  logic [RD_LAT-1:0] valid_sr_reg;
  logic [CNT_W-1:0]  count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_sr_reg <= '0;
      count_reg    <= '0;
    end else begin
      valid_sr_reg[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_sr_reg[i] <= valid_sr_reg[i-1];
      end
      count_reg <= count_reg + CNT_W'(issue) - CNT_W'(rsp_valid);
    end
  end

  assign rsp_valid = valid_sr_reg[RD_LAT-1];
  assign rsp_data  = rsp_valid ? M_din : '0;
  // True when every outstanding beat has returned by the end of this cycle.
  assign empty     = !issue && (count_reg == CNT_W'(rsp_valid));

endmodule

// File: rtl/bus_master.sv
// Initiator engine for one master port of the shared arbitrated bus: takes single/burst
// commands, requests the bus, issues one beat per granted cycle and reports completion.
module bus_master
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int LEN_W  = LEN_W_DEFAULT,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic              M_req,
  input  logic              M_grant,
  output logic              M_wr,
  output logic [ADDR_W-1:0] M_address,
  output logic [DATA_W-1:0] M_dout,
  input  logic [DATA_W-1:0] M_din
);

  state_t            state_reg, state_next;
  logic              wr_reg, wr_next;
  logic [ADDR_W-1:0] cur_addr_reg, cur_addr_next;
  logic [ADDR_W-1:0] last_addr_reg, last_addr_next;
  logic [LEN_W-1:0]  beats_left_reg, beats_left_next;
  logic              done_reg, done_next;
  logic              beat;
  logic              write_beat;
  logic              rd_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      wr_reg         <= 1'b0;
      cur_addr_reg   <= '0;
      last_addr_reg  <= '0;
      beats_left_reg <= '0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_reg         <= wr_next;
      cur_addr_reg   <= cur_addr_next;
      last_addr_reg  <= last_addr_next;
      beats_left_reg <= beats_left_next;
      done_reg       <= done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    wr_next         = wr_reg;
    cur_addr_next   = cur_addr_reg;
    last_addr_next  = last_addr_reg;
    beats_left_next = beats_left_reg;
    done_next       = 1'b0;
    beat            = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          wr_next         = cmd_wr;
          cur_addr_next   = cmd_addr;
          beats_left_next = cmd_len;
          state_next      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (M_grant) state_next = ST_XFER;
      end
      ST_XFER: begin
        // A lost grant simply stalls the burst; address and count hold until it returns.
        if (M_grant) begin
          beat            = 1'b1;
          cur_addr_next   = cur_addr_reg + ADDR_W'(1);
          last_addr_next  = cur_addr_reg;
          beats_left_next = beats_left_reg - LEN_W'(1);
          if (beats_left_reg == '0) begin
            if (wr_reg) begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (rd_empty) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  bus_master_rdpipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .issue     (beat && !wr_reg),
    .M_din     (M_din),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .empty     (rd_empty)
  );

  // Masking with done_reg keeps the next command out until the cycle after done.
  assign cmd_ready  = reset_n && (state_reg == ST_IDLE) && !done_reg;
  assign M_req      = (state_reg == ST_REQ) || (state_reg == ST_XFER);
  assign write_beat = beat && wr_reg;
  assign M_wr       = write_beat;
  assign wr_pop     = write_beat;
  assign M_dout     = write_beat ? wr_data : '0;
  assign M_address  = beat ? cur_addr_reg : last_addr_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master: writes, read bursts, address wrap, arbitration stalls and
// mid-burst reset, with a latency-RD_LAT slave returning addr+0x100.
module tb_bus_master;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_pop;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              done;
  logic              M_req;
  logic              M_grant;
  logic              M_wr;
  logic [ADDR_W-1:0] M_address;
  logic [DATA_W-1:0] M_dout;
  logic [DATA_W-1:0] M_din;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bus_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_data   (wr_data),
    .wr_pop    (wr_pop),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .done      (done),
    .M_req     (M_req),
    .M_grant   (M_grant),
    .M_wr      (M_wr),
    .M_address (M_address),
    .M_dout    (M_dout),
    .M_din     (M_din)
  );

  // Slave: data for the address on the bus appears RD_LAT cycles later as addr+0x100.
  logic [ADDR_W-1:0] addr_pipe [RD_LAT];
  always_ff @(posedge clk) begin
    addr_pipe[0] <= M_address;
    for (int i = 1; i < RD_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign M_din = 32'h100 + {24'h0, addr_pipe[RD_LAT-1]};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Single-command read with continuous grant; command handshakes in the first cycle.
  task automatic read_burst(input string tag, input logic [7:0] a, input int nbeats);
    logic       exp_iss, exp_rsp;
    logic [7:0] ea;
    cyc();
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = a; cmd_len = LEN_W'(nbeats - 1); M_grant = 1'b1;
    #1 chk({tag, " cmd_ready"}, cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
    #1 chk({tag, " req"}, M_req, 1);
    chk({tag, " ready_busy"}, cmd_ready, 0);
    for (int k = 2; k <= nbeats + RD_LAT + 2; k++) begin
      cyc();
      #1;
      exp_iss = (k < 2 + nbeats);
      exp_rsp = (k >= 2 + RD_LAT) && (k < 2 + RD_LAT + nbeats);
      $display("[TB] %s cycle %0d req=%0b addr=%02h rsp=%0b data=%08h done=%0b",
               tag, k, M_req, M_address, rsp_valid, rsp_data, done);
      chk({tag, " M_req"}, M_req, exp_iss);
      chk({tag, " M_wr"}, M_wr, 0);
      if (exp_iss) begin
        ea = 8'(a + 8'(k - 2));
        chk({tag, " addr"}, M_address, ea);
      end
      chk({tag, " rsp_valid"}, rsp_valid, exp_rsp);
      if (exp_rsp) begin
        ea = 8'(a + 8'(k - 2 - RD_LAT));
        chk({tag, " rsp_data"}, rsp_data, 32'h100 + {24'h0, ea});
      end
      chk({tag, " done"}, done, (k == 2 + nbeats + RD_LAT));
    end
    cyc();
    #1 chk({tag, " ready_after"}, cmd_ready, 1);
  endtask

  int pops;
  int idx;
  logic exp_w;

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; M_grant = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst M_req", M_req, 0);
    chk("rst M_wr", M_wr, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst done", done, 0);
    chk("rst cmd_ready", cmd_ready, 0);
    chk("rst M_address", M_address, 0);
    #1 reset_n = 1'b1;
    #1 chk("idle cmd_ready", cmd_ready, 1);

    // 1: single write, immediate grant
    cyc();
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h0A; cmd_len = '0; wr_data = 32'h4; M_grant = 1'b1;
    #1 chk("w1 cmd_ready", cmd_ready, 1);
    cyc(); cmd_valid = 1'b0;
    #1 chk("w1 req", M_req, 1); chk("w1 no beat", M_wr, 0);
    cyc(); #1;
    $display("[TB] w1 beat wr=%0b addr=%02h dout=%08h pop=%0b", M_wr, M_address, M_dout, wr_pop);
    chk("w1 M_wr", M_wr, 1); chk("w1 addr", M_address, 8'h0A);
    chk("w1 dout", M_dout, 32'h4); chk("w1 pop", wr_pop, 1); chk("w1 early done", done, 0);
    cyc(); #1;
    chk("w1 done", done, 1); chk("w1 req off", M_req, 0); chk("w1 M_wr off", M_wr, 0);
    chk("w1 dout off", M_dout, 0); chk("w1 ready in done", cmd_ready, 0);
    cyc(); #1;
    chk("w1 done pulse", done, 0); chk("w1 ready", cmd_ready, 1);

    // 2: read burst; 3: address wrap
    read_burst("rd", 8'h1E, 4);
    read_burst("wrap", 8'hFE, 4);

    // 4: grant withheld five cycles
    cyc();
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h40; cmd_len = 4'd1;
    wr_data = 32'hA000_0000; M_grant = 1'b0;
    #1 chk("ct cmd_ready", cmd_ready, 1);
    for (int c = 1; c <= 5; c++) begin
      cyc(); cmd_valid = 1'b0;
      #1;
      $display("[TB] ct wait %0d req=%0b wr=%0b ready=%0b", c, M_req, M_wr, cmd_ready);
      chk("ct req held", M_req, 1); chk("ct no M_wr", M_wr, 0);
      chk("ct no pop", wr_pop, 0); chk("ct ready low", cmd_ready, 0);
    end
    cyc(); M_grant = 1'b1;
    #1 chk("ct grant seen no beat", M_wr, 0);
    cyc(); #1;
    chk("ct b0 wr", M_wr, 1); chk("ct b0 addr", M_address, 8'h40);
    chk("ct b0 dout", M_dout, 32'hA000_0000); chk("ct b0 pop", wr_pop, 1);
    wr_data = 32'hA000_0001;
    cyc(); #1;
    chk("ct b1 wr", M_wr, 1); chk("ct b1 addr", M_address, 8'h41);
    chk("ct b1 dout", M_dout, 32'hA000_0001);
    cyc(); #1;
    chk("ct done", done, 1); chk("ct req off", M_req, 0);

    // 5: 8-beat write, grant lost for two cycles after beat 2
    cyc();
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h80; cmd_len = 4'd7;
    pops = 0; wr_data = 32'h1000; M_grant = 1'b1;
    #1 chk("gd cmd_ready", cmd_ready, 1);
    cyc(); cmd_valid = 1'b0;
    for (int k = 2; k <= 12; k++) begin
      cyc();
      M_grant = !(k == 4 || k == 5);
      wr_data = 32'h1000 + pops;
      #1;
      exp_w = (k == 2 || k == 3 || (k >= 6 && k <= 11));
      idx   = (k < 4) ? k - 2 : k - 4;
      $display("[TB] gd cycle %0d gnt=%0b wr=%0b pop=%0b addr=%02h dout=%08h done=%0b",
               k, M_grant, M_wr, wr_pop, M_address, M_dout, done);
      chk("gd M_wr", M_wr, exp_w);
      chk("gd pop", wr_pop, exp_w);
      chk("gd req", M_req, (k <= 11));
      chk("gd done", done, (k == 12));
      if (exp_w) begin
        chk("gd addr", M_address, 8'(8'h80 + idx));
        chk("gd dout", M_dout, 32'h1000 + idx);
      end else if (k < 12) begin
        chk("gd addr hold", M_address, 8'h81);
        chk("gd dout zero", M_dout, 0);
      end
      if (wr_pop) pops++;
    end
    chk("gd pop total", pops, 8);

    // 6: reset in the middle of a read burst
    cyc();
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h30; cmd_len = 4'd7; M_grant = 1'b1;
    cyc(); cmd_valid = 1'b0;
    repeat (3) cyc();
    #1 chk("mr rsp before", rsp_valid, 1); chk("mr data before", rsp_data, 32'h130);
    chk("mr req before", M_req, 1);
    #1 reset_n = 1'b0;
    #1;
    $display("[TB] mr reset req=%0b rsp=%0b done=%0b", M_req, rsp_valid, done);
    chk("mr req drop", M_req, 0); chk("mr rsp drop", rsp_valid, 0);
    chk("mr done", done, 0); chk("mr M_wr", M_wr, 0);
    cyc(); cyc();
    reset_n = 1'b1;
    #1 chk("mr idle ready", cmd_ready, 1); chk("mr no done", done, 0);
    read_burst("post", 8'h55, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
